// File: rtl/avr_irq_ctl_pkg.sv
// rtl/avr_irq_ctl_pkg.sv - register map shared by the interrupt controller, MMIO decoder and drivers
package avr_irq_ctl_pkg;

    // Register offsets within the 256-byte slot.
    localparam logic [7:0] IRQ_PEND   = 8'h00;  // R / W1C (edge bits only)
    localparam logic [7:0] IRQ_ENABLE = 8'h01;  // RW per-source mask
    localparam logic [7:0] IRQ_EDGE   = 8'h02;  // RW, 1 = edge, 0 = level
    localparam logic [7:0] IRQ_ACTIVE = 8'h03;  // R, PEND & ENABLE
    localparam logic [7:0] IRQ_VECT   = 8'h04;  // R, {iflag, zeros, ivect}
    localparam logic [7:0] IRQ_SWSET  = 8'h05;  // W, software set of edge pending bits
    localparam logic [7:0] IRQ_GIE    = 8'h06;  // RW bit 0, global interrupt enable

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - combinational lowest-index-first priority encoder
//
// Ports:
//   req  in   NSRC  request vector, bit 0 has the highest priority
//   any  out  1     at least one request bit is set
//   idx  out  VW    index of the lowest set bit, 0 when req is empty
module irq_prio_enc #(
    parameter int NSRC = 8,
    parameter int VW   = 3
) (
    input  logic [NSRC-1:0] req,
    output logic            any,
    output logic [VW-1:0]   idx
);

    always_comb begin
        any = |req;
        idx = '0;
        // Scan from the top down so the lowest set bit is the last assignment.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = VW'(i);
            end
        end
    end

endmodule

// File: rtl/avr_irq_ctl.sv
// rtl/avr_irq_ctl.sv - MMIO interrupt controller driving the AVR core iflag/ivect inputs
//
// Ports:
//   clk        in   1     system clock
//   rst_n      in   1     asynchronous active-low reset
//   irq_src    in   NSRC  raw interrupt lines, bit 0 highest priority
//   reg_re     in   1     register read strobe (slot already decoded)
//   reg_we     in   1     register write strobe
//   reg_a      in   8     register offset within the slot
//   reg_wdata  in   8     write data
//   reg_rdata  out  8     registered read data, holds until the next read
//   iack       in   1     core has taken the vector on ivect
//   iflag      out  1     registered interrupt request
//   ivect      out  VW    registered vector number, valid while iflag=1
module avr_irq_ctl
    import avr_irq_ctl_pkg::*;
#(
    parameter int NSRC = 8,
    parameter int VW   = 3,
    parameter int SYNC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] irq_src,
    input  logic            reg_re,
    input  logic            reg_we,
    input  logic [7:0]      reg_a,
    input  logic [7:0]      reg_wdata,
    output logic [7:0]      reg_rdata,
    input  logic            iack,
    output logic            iflag,
    output logic [VW-1:0]   ivect
);

    logic [NSRC-1:0] s;
    logic [NSRC-1:0] q;
    logic [NSRC-1:0] rise;

    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] pend_nxt;
    logic [NSRC-1:0] enable;
    logic [NSRC-1:0] edge_mode;
    logic            gie;

    logic [NSRC-1:0] active;
    logic            enc_any;
    logic [VW-1:0]   enc_idx;
    logic [7:0]      rd_mux;

    logic wr_pend;
    logic wr_enable;
    logic wr_edge;
    logic wr_swset;
    logic wr_gie;
    logic iack_take;

    // Source sampling: optional two-flop synchronizer in front of the edge detector.
    generate
        if (SYNC != 0) begin : g_sync
            logic [NSRC-1:0] meta;
            logic [NSRC-1:0] sync;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta <= '0;
                    sync <= '0;
                end else begin
                    meta <= irq_src;
                    sync <= meta;
                end
            end
            assign s = sync;
        end else begin : g_nosync
            assign s = irq_src;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= s;
        end
    end

    assign rise = s & ~q;

    assign wr_pend   = reg_we && (reg_a == IRQ_PEND);
    assign wr_enable = reg_we && (reg_a == IRQ_ENABLE);
    assign wr_edge   = reg_we && (reg_a == IRQ_EDGE);
    assign wr_swset  = reg_we && (reg_a == IRQ_SWSET);
    assign wr_gie    = reg_we && (reg_a == IRQ_GIE);

    // An acknowledge only means something while a vector is actually presented.
    assign iack_take = iack && iflag;

    always_comb begin
        pend_nxt = pend;
        for (int i = 0; i < NSRC; i++) begin
            if (!edge_mode[i]) begin
                pend_nxt[i] = s[i];
            end else if (rise[i] || (wr_swset && reg_wdata[i])) begin
                // Set beats clear so an edge arriving during a clear is not lost.
                pend_nxt[i] = 1'b1;
            end else if ((wr_pend && reg_wdata[i]) ||
                         (iack_take && (ivect == VW'(i)))) begin
                pend_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= '0;
            enable    <= '0;
            edge_mode <= '0;
            gie       <= 1'b0;
        end else begin
            pend <= pend_nxt;
            if (wr_enable) begin
                enable <= reg_wdata[NSRC-1:0];
            end
            if (wr_edge) begin
                edge_mode <= reg_wdata[NSRC-1:0];
            end
            if (wr_gie) begin
                gie <= reg_wdata[0];
            end
        end
    end

    assign active = pend & enable & {NSRC{gie}};

    irq_prio_enc #(
        .NSRC (NSRC),
        .VW   (VW)
    ) u_prio_enc (
        .req (active),
        .any (enc_any),
        .idx (enc_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iflag <= 1'b0;
            ivect <= '0;
        end else begin
            iflag <= enc_any;
            ivect <= enc_idx;
        end
    end

    // Read mux works on current register values, so a same-cycle write is not yet visible.
    always_comb begin
        rd_mux = '0;
        case (reg_a)
            IRQ_PEND:   rd_mux[NSRC-1:0] = pend;
            IRQ_ENABLE: rd_mux[NSRC-1:0] = enable;
            IRQ_EDGE:   rd_mux[NSRC-1:0] = edge_mode;
            IRQ_ACTIVE: rd_mux[NSRC-1:0] = pend & enable;
            IRQ_VECT: begin
                rd_mux[7]      = iflag;
                rd_mux[VW-1:0] = ivect;
            end
            IRQ_GIE:    rd_mux[0] = gie;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_rdata <= '0;
        end else if (reg_re) begin
            reg_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_avr_irq_ctl.sv
// tb/tb_avr_irq_ctl.sv - scoreboard bench for avr_irq_ctl against a behavioural model
module tb_avr_irq_ctl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_src;
    logic       reg_re;
    logic       reg_we;
    logic [7:0] reg_a;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       iack;
    logic       iflag;
    logic [2:0] ivect;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avr_irq_ctl #(.NSRC(8), .VW(3), .SYNC(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_src   (irq_src),
        .reg_re    (reg_re),
        .reg_we    (reg_we),
        .reg_a     (reg_a),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .iack      (iack),
        .iflag     (iflag),
        .ivect     (ivect)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: per-source pending rules, lowest active index wins.
    bit   [7:0] m_pend, m_en, m_edge, m_q;
    bit         m_gie, m_iflag, m_rdv;
    int         m_ivect;
    bit   [7:0] exp_q[$];

    function automatic bit [7:0] model_read(input bit [7:0] a);
        case (a)
            8'h00:   return m_pend;
            8'h01:   return m_en;
            8'h02:   return m_edge;
            8'h03:   return m_pend & m_en;
            8'h04:   return {m_iflag, 4'b0000, 3'(m_ivect)};
            8'h06:   return {7'b0, m_gie};
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pend = 0; m_en = 0; m_edge = 0; m_q = 0; m_gie = 0;
                m_iflag = 0; m_ivect = 0; m_rdv = 0;
                exp_q.delete();
            end else begin
                bit [7:0] act, np;
                bit       nflag;
                int       nvec, taken;
                m_rdv = reg_re;
                if (reg_re) exp_q.push_back(model_read(reg_a));
                act   = m_gie ? (m_pend & m_en) : 8'h00;
                nflag = (act != 0);
                nvec  = 0;
                for (int i = 0; i < 8; i++) begin
                    if (act[i]) begin
                        nvec = i;
                        break;
                    end
                end
                taken = (iack && m_iflag) ? m_ivect : -1;
                np = m_pend;
                for (int i = 0; i < 8; i++) begin
                    if (!m_edge[i])
                        np[i] = irq_src[i];
                    else if ((irq_src[i] && !m_q[i]) || (reg_we && reg_a == 8'h05 && reg_wdata[i]))
                        np[i] = 1;
                    else if ((reg_we && reg_a == 8'h00 && reg_wdata[i]) || taken == i)
                        np[i] = 0;
                end
                if (reg_we && reg_a == 8'h01) m_en = reg_wdata;
                if (reg_we && reg_a == 8'h02) m_edge = reg_wdata;
                if (reg_we && reg_a == 8'h06) m_gie = reg_wdata[0];
                m_q     = irq_src;
                m_pend  = np;
                m_iflag = nflag;
                m_ivect = nvec;
            end
        end
    end

    // Monitor: compares presented outputs against the model, read data against the queue.
    always @(negedge clk) begin
        chk("iflag", int'(iflag), int'(m_iflag));
        chk("ivect", int'(ivect), m_ivect);
        if (!rst_n) begin
            chk("rdata_in_reset", int'(reg_rdata), 0);
        end else if (m_rdv) begin
            if (exp_q.size() == 0) begin
                chk("rdata_queue_empty", 1, 0);
            end else begin
                chk("reg_rdata", int'(reg_rdata), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input bit [7:0] a, input bit [7:0] d);
        reg_we = 1; reg_a = a; reg_wdata = d;
        tick();
        reg_we = 0;
    endtask

    task automatic rd(input bit [7:0] a);
        reg_re = 1; reg_a = a;
        tick();
        reg_re = 0;
    endtask

    task automatic pulse_iack();
        iack = 1;
        tick();
        iack = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0; irq_src = 8'hFF; reg_re = 0; reg_we = 0;
        reg_a = 0; reg_wdata = 0; iack = 0;
        tick();
        rd(8'h00);
        chk("reset_pend_read", int'(reg_rdata), 0);
        chk("reset_iflag", int'(iflag), 0);
        irq_src = 8'h00;
        tick();
        rst_n = 1;
        tick();

        // Level source
        wr(8'h02, 8'h00); wr(8'h01, 8'h04); wr(8'h06, 8'h01);
        irq_src = 8'h04;
        tick(); tick();
        chk("level_iflag", int'(iflag), 1);
        chk("level_ivect", int'(ivect), 2);
        irq_src = 8'h00;
        tick(); tick();
        chk("level_drop", int'(iflag), 0);

        // Edge sources with acknowledge sequencing
        wr(8'h02, 8'hFF); wr(8'h01, 8'hFF);
        irq_src = 8'h22;
        tick();
        irq_src = 8'h00;
        tick();
        chk("edge_first_vect", int'(ivect), 1);
        pulse_iack(); tick();
        chk("edge_second_vect", int'(ivect), 5);
        chk("edge_second_flag", int'(iflag), 1);
        pulse_iack(); tick();
        chk("edge_all_taken", int'(iflag), 0);
        rd(8'h00);
        chk("edge_pend_empty", int'(reg_rdata), 0);

        // W1C colliding with a rising edge
        irq_src = 8'h08; reg_we = 1; reg_a = 8'h00; reg_wdata = 8'h08;
        tick();
        reg_we = 0; irq_src = 8'h00;
        rd(8'h00);
        chk("collision_pend", int'(reg_rdata), 8'h08);
        wr(8'h00, 8'hFF);

        // Masking
        irq_src = 8'h01; tick(); irq_src = 8'h00; tick();
        wr(8'h01, 8'h00); tick();
        chk("mask_iflag", int'(iflag), 0);
        rd(8'h00);
        chk("mask_pend_kept", int'(reg_rdata), 8'h01);
        wr(8'h01, 8'h01); tick();
        chk("unmask_iflag", int'(iflag), 1);
        chk("unmask_ivect", int'(ivect), 0);

        // Register access
        wr(8'h01, 8'h80); wr(8'h05, 8'h80); tick(); tick();
        rd(8'h04);
        chk("vect_read", int'(reg_rdata), 8'h87);
        rd(8'h7F);
        chk("unmapped_read", int'(reg_rdata), 0);

        // Randomized traffic with one mid-run reset
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst_n = 0; tick(); tick(); rst_n = 1;
            end
            if ($urandom_range(0, 3) == 0) irq_src = 8'($urandom);
            reg_re = ($urandom_range(0, 2) == 0);
            reg_we = ($urandom_range(0, 4) == 0);
            reg_a  = ($urandom_range(0, 8) == 8) ? 8'h7F : 8'($urandom_range(0, 7));
            reg_wdata = 8'($urandom);
            if (reg_we && reg_a == 8'h06 && $urandom_range(0, 3) != 0) reg_wdata[0] = 1'b1;
            iack = ($urandom_range(0, 3) == 0);
            tick();
        end
        reg_re = 0; reg_we = 0; iack = 0;
        tick(); tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
